// File: rtl/ysyx_22041412_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states
// and the alignment mask used by the error check.
package ysyx_22041412_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_WAIT   = 2'b01,
    ST_ACCESS = 2'b10,
    ST_RESP   = 2'b11
  } state_e;

  // Low address bits that must be zero for an access of the given size.
  function automatic logic [2:0] align_mask(input logic [1:0] size);
    logic [2:0] mask;
    case (size)
      SZ_B:    mask = 3'b000;
      SZ_H:    mask = 3'b001;
      SZ_W:    mask = 3'b011;
      default: mask = 3'b111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/ysyx_22041412_dmem_lane.sv
// Combinational lane logic: merges store bytes into a dword entry and
// extracts/extends load data from it.
module ysyx_22041412_dmem_lane
  import ysyx_22041412_pkg::*;
(
  input  logic [63:0] entry_i,
  input  logic [2:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [63:0] wdata_i,
  output logic [63:0] merged_o,
  output logic [63:0] rdata_o
);

  logic [5:0]  shamt_s;
  logic [7:0]  size_mask_s;
  logic [7:0]  byte_en_s;
  logic [63:0] wshift_s;
  logic [63:0] rshift_s;

  assign shamt_s   = {lane_i, 3'b000};
  assign wshift_s  = wdata_i << shamt_s;
  assign rshift_s  = entry_i >> shamt_s;
  assign byte_en_s = size_mask_s << lane_i;

  // Byte enables for the access size, before lane shifting.
  always_comb begin
    size_mask_s = 8'h00;
    case (size_i)
      SZ_B:    size_mask_s = 8'h01;
      SZ_H:    size_mask_s = 8'h03;
      SZ_W:    size_mask_s = 8'h0F;
      default: size_mask_s = 8'hFF;
    endcase
  end

  // Store merge: enabled bytes take shifted write data, others keep the entry.
  always_comb begin
    merged_o = entry_i;
    for (int i = 0; i < 8; i++) begin
      if (byte_en_s[i]) begin
        merged_o[8*i +: 8] = wshift_s[8*i +: 8];
      end else begin
        merged_o[8*i +: 8] = entry_i[8*i +: 8];
      end
    end
  end

  // Load extract with sign or zero extension; dword ignores unsigned_i.
  always_comb begin
    rdata_o = 64'd0;
    case (size_i)
      SZ_B:    rdata_o = {{56{~unsigned_i & rshift_s[7]}},  rshift_s[7:0]};
      SZ_H:    rdata_o = {{48{~unsigned_i & rshift_s[15]}}, rshift_s[15:0]};
      SZ_W:    rdata_o = {{32{~unsigned_i & rshift_s[31]}}, rshift_s[31:0]};
      default: rdata_o = rshift_s;
    endcase
  end

endmodule

// File: rtl/ysyx_22041412_dmem_resp.sv
// Data-memory responder: one request at a time, programmable wait, then a
// single-cycle access on a dword array and a held response.
module ysyx_22041412_dmem_resp
  import ysyx_22041412_pkg::*;
#(
  parameter int unsigned          ADDR_WIDTH = 64,
  parameter int unsigned          DEPTH      = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(64'h0000_0000_8000_0000),
  parameter int unsigned          LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_wen_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [63:0]           req_wdata_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [63:0]           resp_rdata_o,
  output logic                  resp_err_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [3:0]  LAT_Q = 4'(LATENCY);

  state_e                  state_q;
  logic [3:0]              cnt_q;
  logic                    wen_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [63:0]             wdata_q;
  logic [1:0]              size_q;
  logic                    uns_q;
  logic                    req_ready_q;
  logic                    resp_valid_q;
  logic [63:0]             rdata_q;
  logic                    err_q;
  logic [63:0]             mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0]   off_s;
  logic [IDX_W-1:0]        idx_s;
  logic                    err_s;
  logic                    mem_we_s;
  logic [63:0]             entry_s;
  logic [63:0]             merged_s;
  logic [63:0]             load_s;

  assign off_s    = addr_q - BASE_ADDR;
  assign idx_s    = off_s[IDX_W+2:3];
  // Range is checked on the full offset so nothing past DEPTH can alias a low entry.
  assign err_s    = (addr_q < BASE_ADDR)
                  | ((off_s >> 3) >= ADDR_WIDTH'(DEPTH))
                  | ((addr_q[2:0] & align_mask(size_q)) != 3'b000);
  assign mem_we_s = (state_q == ST_ACCESS) & wen_q & ~err_s;
  assign entry_s  = mem_q[idx_s];

  ysyx_22041412_dmem_lane u_lane (
    .entry_i    (entry_s),
    .lane_i     (addr_q[2:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .wdata_i    (wdata_q),
    .merged_o   (merged_s),
    .rdata_o    (load_s)
  );

  // Request FSM with wait counter, capture registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      wen_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= 64'd0;
      size_q       <= SZ_B;
      uns_q        <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      rdata_q      <= 64'd0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid_i && req_ready_q) begin
            wen_q       <= req_wen_i;
            addr_q      <= req_addr_i;
            wdata_q     <= req_wdata_i;
            size_q      <= req_size_i;
            uns_q       <= req_unsigned_i;
            cnt_q       <= LAT_Q;
            req_ready_q <= 1'b0;
            state_q     <= (LAT_Q == 4'd0) ? ST_ACCESS : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_q <= 4'd1) begin
            cnt_q   <= 4'd0;
            state_q <= ST_ACCESS;
          end else begin
            cnt_q   <= cnt_q - 4'd1;
          end
        end
        ST_ACCESS: begin
          rdata_q      <= (wen_q || err_s) ? 64'd0 : load_s;
          err_q        <= err_s;
          resp_valid_q <= 1'b1;
          state_q      <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready_i) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            rdata_q      <= 64'd0;
            err_q        <= 1'b0;
            state_q      <= ST_IDLE;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Storage is deliberately not reset; a reset before ACCESS leaves it untouched.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[idx_s] <= merged_s;
    end
  end

  assign req_ready_o  = req_ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;

endmodule

// File: tb/tb_ysyx_22041412_dmem_resp.sv
// Randomized bench for the data-memory responder against a byte-level model.
module tb_ysyx_22041412_dmem_resp;

  localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;
  localparam int unsigned WIN  = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid0 = 1'b0, req_valid1 = 1'b0;
  logic        req_wen = 1'b0;
  logic [63:0] req_addr = 64'd0, req_wdata = 64'd0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic        resp_ready = 1'b1;
  logic        rdy0, rv0, er0, rdy1, rv1, er1;
  logic [63:0] rd0, rd1;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  mm [WIN];
  logic [63:0] last_rdata;
  logic        last_err;
  int          last_lat;

  always #5 clk = ~clk;

  ysyx_22041412_dmem_resp #(.LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid0), .req_ready_o(rdy0),
    .req_wen_i(req_wen), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_size_i(req_size), .req_unsigned_i(req_unsigned), .resp_valid_o(rv0),
    .resp_ready_i(resp_ready), .resp_rdata_o(rd0), .resp_err_o(er0)
  );

  ysyx_22041412_dmem_resp #(.LATENCY(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid1), .req_ready_o(rdy1),
    .req_wen_i(req_wen), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_size_i(req_size), .req_unsigned_i(req_unsigned), .resp_valid_o(rv1),
    .resp_ready_i(resp_ready), .resp_rdata_o(rd1), .resp_err_o(er1)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one request with resp_ready high; returns data, error and latency.
  task automatic do_req(input logic sel, input logic wen, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [1:0] sz, input logic uns);
    int k;
    @(negedge clk);
    req_wen = wen; req_addr = addr; req_wdata = wdata; req_size = sz; req_unsigned = uns;
    if (sel) req_valid1 = 1'b1; else req_valid0 = 1'b1;
    k = 0;
    while (!(sel ? rdy1 : rdy0) && k < 50) begin @(negedge clk); k++; end
    if (k >= 50) check_eq("accept_timeout", 64'(k), 64'd0);
    @(negedge clk);
    req_valid0 = 1'b0; req_valid1 = 1'b0;
    last_lat = 1;
    while (!(sel ? rv1 : rv0) && last_lat < 50) begin @(negedge clk); last_lat++; end
    if (last_lat >= 50) check_eq("resp_timeout", 64'(last_lat), 64'd0);
    last_rdata = sel ? rd1 : rd0;
    last_err   = sel ? er1 : er0;
  endtask

  // Model-checked operation on the LATENCY=2 instance.
  task automatic run_op(input string tag, input logic wen, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [1:0] sz, input logic uns);
    int n;
    logic [63:0] off, exp_d;
    logic exp_e;
    n = 1 << sz;
    exp_e = (addr < BASE) || (addr >= BASE + 64'(4096 * 8)) || ((addr % 64'(n)) != 64'd0);
    exp_d = 64'd0;
    if (!exp_e) begin
      off = addr - BASE;
      if (wen) begin
        for (int i = 0; i < n; i++) mm[off + 64'(i)] = wdata[8*i +: 8];
      end else begin
        for (int i = 0; i < n; i++) exp_d = exp_d | (64'(mm[off + 64'(i)]) << (8 * i));
        if (!uns && n < 8 && exp_d[8*n-1]) exp_d = exp_d | (~64'd0 << (8 * n));
      end
    end
    do_req(1'b0, wen, addr, wdata, sz, uns);
    check_eq({tag, "_rdata"}, last_rdata, exp_d);
    check_eq({tag, "_err"}, 64'(last_err), 64'(exp_e));
    check_eq({tag, "_lat"}, 64'(last_lat), 64'd4);
  endtask

  initial begin
    logic [63:0] a, w;
    int r, last, nresp;
    logic [1:0] sz;

    // Reset values
    repeat (2) @(negedge clk);
    check_eq("rst_req_ready", 64'(rdy0), 64'd1);
    check_eq("rst_resp_valid", 64'(rv0), 64'd0);
    check_eq("rst_rdata", rd0, 64'd0);
    check_eq("rst_err", 64'(er0), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Fill the model window with known data
    for (int i = 0; i < WIN / 8; i++)
      run_op("fill", 1'b1, BASE + 64'(8 * i), {$urandom, $urandom}, 2'd3, 1'b0);

    // Reset mid-WAIT drops the store
    run_op("t1_pre", 1'b1, BASE, 64'h0123_4567_89AB_CDEF, 2'd3, 1'b0);
    @(negedge clk);
    req_wen = 1'b1; req_addr = BASE; req_wdata = 64'h11; req_size = 2'd0; req_valid0 = 1'b1;
    @(negedge clk);
    req_valid0 = 1'b0;
    check_eq("t1_wait_ready", 64'(rdy0), 64'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("t1_ready", 64'(rdy0), 64'd1);
    check_eq("t1_valid", 64'(rv0), 64'd0);
    run_op("t1_ld", 1'b0, BASE, 64'd0, 2'd3, 1'b0);
    check_eq("t1_entry0", last_rdata, 64'h0123_4567_89AB_CDEF);

    // Directed loads after a dword store
    run_op("t2_sd", 1'b1, BASE + 64'h8, 64'h8877_6655_4433_2211, 2'd3, 1'b0);
    run_op("t2_lb", 1'b0, BASE + 64'hF, 64'd0, 2'd0, 1'b0);
    check_eq("t2_lb_lit", last_rdata, 64'hFFFF_FFFF_FFFF_FF88);
    run_op("t2_lbu", 1'b0, BASE + 64'hF, 64'd0, 2'd0, 1'b1);
    check_eq("t2_lbu_lit", last_rdata, 64'h88);
    run_op("t2_lh", 1'b0, BASE + 64'hA, 64'd0, 2'd1, 1'b0);
    check_eq("t2_lh_lit", last_rdata, 64'h4433);

    // Byte store merge
    run_op("t3_sb", 1'b1, BASE + 64'h9, 64'hAB, 2'd0, 1'b0);
    run_op("t3_ld", 1'b0, BASE + 64'h8, 64'd0, 2'd3, 1'b0);
    check_eq("t3_ld_lit", last_rdata, 64'h8877_6655_4433_AB11);

    // Errors: misaligned and out of range (must not alias entry 0)
    run_op("t4_lw", 1'b0, BASE + 64'h2, 64'd0, 2'd2, 1'b0);
    check_eq("t4_lw_err_lit", 64'(last_err), 64'd1);
    run_op("t4_sd", 1'b1, BASE + 64'h8000, 64'hDEAD_BEEF_DEAD_BEEF, 2'd3, 1'b0);
    check_eq("t4_sd_err_lit", 64'(last_err), 64'd1);
    run_op("t4_ld0", 1'b0, BASE, 64'd0, 2'd3, 1'b0);

    // Back-pressure on the response
    @(negedge clk);
    resp_ready = 1'b0;
    req_wen = 1'b0; req_addr = BASE + 64'h8; req_size = 2'd3; req_unsigned = 1'b0;
    req_valid0 = 1'b1;
    @(negedge clk);
    req_valid0 = 1'b0;
    r = 1;
    while (!rv0 && r < 50) begin
      check_eq("t5_ready_low", 64'(rdy0), 64'd0);
      @(negedge clk); r++;
    end
    check_eq("t5_lat", 64'(r), 64'd4);
    for (int i = 0; i < 3; i++) begin
      check_eq("t5_valid_hold", 64'(rv0), 64'd1);
      check_eq("t5_rdata_hold", rd0, 64'h8877_6655_4433_AB11);
      check_eq("t5_err_hold", 64'(er0), 64'd0);
      check_eq("t5_ready_hold", 64'(rdy0), 64'd0);
      if (i == 2) resp_ready = 1'b1;
      @(negedge clk);
    end
    check_eq("t5_valid_drop", 64'(rv0), 64'd0);
    check_eq("t5_ready_back", 64'(rdy0), 64'd1);

    // Randomized operations
    for (int it = 0; it < 60; it++) begin
      r  = int'($urandom_range(0, 9));
      sz = 2'($urandom_range(0, 3));
      w  = {$urandom, $urandom};
      if (r == 0)      a = BASE - 64'($urandom_range(1, 16));
      else if (r == 1) a = BASE + 64'h8000 + 64'($urandom_range(0, 64));
      else             a = BASE + 64'($urandom_range(0, WIN - 1));
      run_op("rnd", 1'($urandom_range(0, 1)), a, w, sz, 1'($urandom_range(0, 1)));
    end

    // LATENCY=0 instance: back-to-back loads
    do_req(1'b1, 1'b1, BASE + 64'h10, 64'h1122_3344_5566_7788, 2'd3, 1'b0);
    check_eq("t6_sd_lat", 64'(last_lat), 64'd2);
    check_eq("t6_sd_err", 64'(last_err), 64'd0);
    @(negedge clk);
    req_wen = 1'b0; req_addr = BASE + 64'h10; req_size = 2'd2; req_unsigned = 1'b1;
    req_valid1 = 1'b1;
    last = -1; nresp = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (rv1) begin
        check_eq("t6_rdata", rd1, 64'h5566_7788);
        if (last >= 0) check_eq("t6_gap", 64'(c - last), 64'd3);
        last = c; nresp++;
      end
    end
    req_valid1 = 1'b0;
    check_eq("t6_count", 64'(nresp), 64'd3);
    r = 0;
    while (!(rdy1 && !rv1) && r < 20) begin @(negedge clk); r++; end
    check_eq("t6_drain", 64'(rdy1), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
